// File: rtl/piu_pchinfo_tx.sv
// Patch-info transmitter: serialises one decoded instruction into one beat per
// target patch towards the PFU, honouring pchwr_stall backpressure.
module piu_pchinfo_tx #(
  parameter int unsigned          OPCODE_BW      = 4,
  parameter int unsigned          PCHIDX_BW      = 6,
  parameter int unsigned          NUM_PCH        = 36,
  parameter logic [OPCODE_BW-1:0] RUN_ESM_OPCODE = OPCODE_BW'(1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic [OPCODE_BW-1:0] instr_opcode,
  input  logic [PCHIDX_BW-1:0] instr_pchidx,
  input  logic [PCHIDX_BW:0]   instr_pchnum,
  output logic                 instr_ready,
  input  logic                 pchwr_stall,
  output logic                 topsu_valid,
  output logic [OPCODE_BW-1:0] piu_opcode,
  output logic [PCHIDX_BW-1:0] piu_pchidx,
  output logic                 last_pchinfo,
  output logic                 busy
);

  localparam int unsigned CNT_BW = PCHIDX_BW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state, state_nxt;
  logic                 valid_nxt;
  logic [OPCODE_BW-1:0] opcode_nxt;
  logic [PCHIDX_BW-1:0] pchidx_nxt;
  logic                 last_nxt;
  logic                 busy_nxt;
  logic [CNT_BW-1:0]    cnt, cnt_nxt;

  logic                 xfer_c;
  logic                 accept_c;
  logic [CNT_BW-1:0]    idx_sum_c;
  logic [PCHIDX_BW-1:0] idx_inc_c;

  // Ready also during the final transfer so instructions chain without a bubble
  assign xfer_c      = topsu_valid & ~pchwr_stall;
  assign instr_ready = (state == IDLE) | ((state == SEND) & xfer_c & last_pchinfo);
  assign accept_c    = instr_valid & instr_ready;

  // Next patch index, wrapping modulo NUM_PCH
  assign idx_sum_c = {1'b0, piu_pchidx} + CNT_BW'(1);
  assign idx_inc_c = PCHIDX_BW'((idx_sum_c >= CNT_BW'(NUM_PCH)) ? idx_sum_c - CNT_BW'(NUM_PCH)
                                                                : idx_sum_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      topsu_valid  <= 1'b0;
      piu_opcode   <= '0;
      piu_pchidx   <= '0;
      last_pchinfo <= 1'b0;
      busy         <= 1'b0;
      cnt          <= '0;
    end else begin
      state        <= state_nxt;
      topsu_valid  <= valid_nxt;
      piu_opcode   <= opcode_nxt;
      piu_pchidx   <= pchidx_nxt;
      last_pchinfo <= last_nxt;
      busy         <= busy_nxt;
      cnt          <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    valid_nxt  = topsu_valid;
    opcode_nxt = piu_opcode;
    pchidx_nxt = piu_pchidx;
    last_nxt   = last_pchinfo;
    cnt_nxt    = cnt;

    if (accept_c) begin
      if (instr_opcode == RUN_ESM_OPCODE) begin
        state_nxt  = SEND;
        valid_nxt  = 1'b1;
        opcode_nxt = instr_opcode;
        pchidx_nxt = '0;
        last_nxt   = 1'b1;
        cnt_nxt    = '0;
      end else if (instr_pchnum == '0) begin
        // Empty instruction is consumed without emitting a beat
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
        cnt_nxt   = '0;
      end else begin
        state_nxt  = SEND;
        valid_nxt  = 1'b1;
        opcode_nxt = instr_opcode;
        pchidx_nxt = instr_pchidx;
        last_nxt   = (instr_pchnum == CNT_BW'(1));
        cnt_nxt    = instr_pchnum - CNT_BW'(1);
      end
    end else if ((state == SEND) && xfer_c) begin
      if (!last_pchinfo) begin
        pchidx_nxt = idx_inc_c;
        cnt_nxt    = cnt - CNT_BW'(1);
        last_nxt   = (cnt == CNT_BW'(1));
      end else begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
      end
    end

    busy_nxt = (state_nxt == SEND);
  end

endmodule

// File: tb/tb_piu_pchinfo_tx.sv
// Self-checking bench for piu_pchinfo_tx: directed scenarios plus random traffic
// compared cycle by cycle against a queue-of-pending-beats reference model.
module tb_piu_pchinfo_tx;

  localparam int unsigned NUM_PCH = 36;
  localparam logic [3:0]  RUN_ESM = 4'd1;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [3:0] instr_opcode;
  logic [5:0] instr_pchidx;
  logic [6:0] instr_pchnum;
  logic       instr_ready;
  logic       pchwr_stall;
  logic       topsu_valid;
  logic [3:0] piu_opcode;
  logic [5:0] piu_pchidx;
  logic       last_pchinfo;
  logic       busy;

  piu_pchinfo_tx dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_opcode (instr_opcode),
    .instr_pchidx (instr_pchidx),
    .instr_pchnum (instr_pchnum),
    .instr_ready  (instr_ready),
    .pchwr_stall  (pchwr_stall),
    .topsu_valid  (topsu_valid),
    .piu_opcode   (piu_opcode),
    .piu_pchidx   (piu_pchidx),
    .last_pchinfo (last_pchinfo),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op;
    logic [5:0] idx;
    logic       last;
  } beat_t;

  beat_t      pend[$];
  logic [3:0] held_op;
  logic [5:0] held_idx;
  int         nbeats_model;
  int         nbeats_dut;
  int         npass;
  int         ntotal;
  logic       last_acc;

  // Beats actually transferred by the DUT
  always @(posedge clk)
    if (rst === 1'b0 && topsu_valid === 1'b1 && pchwr_stall === 1'b0) nbeats_dut++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input logic v, input logic [3:0] op, input logic [5:0] idx,
                      input logic [6:0] num, input logic stall, input logic r);
    beat_t b;
    logic  exp_ready;
    @(negedge clk);
    instr_valid  = v;
    instr_opcode = op;
    instr_pchidx = idx;
    instr_pchnum = num;
    pchwr_stall  = stall;
    rst          = r;
    #1;
    exp_ready = (pend.size() == 0) || (pend.size() == 1 && !stall);
    if (pend.size() > 0) begin
      b = pend[0];
      chk("topsu_valid", 32'(topsu_valid), 32'd1);
      chk("piu_opcode", 32'(piu_opcode), 32'(b.op));
      chk("piu_pchidx", 32'(piu_pchidx), 32'(b.idx));
      chk("last_pchinfo", 32'(last_pchinfo), 32'(b.last));
    end else begin
      chk("topsu_valid_idle", 32'(topsu_valid), 32'd0);
      chk("piu_opcode_hold", 32'(piu_opcode), 32'(held_op));
      chk("piu_pchidx_hold", 32'(piu_pchidx), 32'(held_idx));
      chk("last_pchinfo_idle", 32'(last_pchinfo), 32'd0);
    end
    chk("busy", 32'(busy), 32'(pend.size() > 0));
    chk("instr_ready", 32'(instr_ready), 32'(exp_ready));
    last_acc = v && exp_ready && !r;
    if (r) begin
      pend.delete();
      held_op  = '0;
      held_idx = '0;
    end else begin
      if (pend.size() > 0 && !stall) begin
        void'(pend.pop_front());
        nbeats_model++;
      end
      if (last_acc) begin
        if (op == RUN_ESM) begin
          pend.push_back('{op: op, idx: 6'd0, last: 1'b1});
        end else begin
          for (int k = 0; k < int'(num); k++)
            pend.push_back('{op: op, idx: 6'((int'(idx) + k) % NUM_PCH),
                             last: (k == int'(num) - 1)});
        end
      end
      if (pend.size() > 0) begin
        held_op  = pend[0].op;
        held_idx = pend[0].idx;
      end
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [5:0] idx, input logic [6:0] num);
    last_acc = 1'b0;
    for (int i = 0; i < 100 && !last_acc; i++) step(1'b1, op, idx, num, 1'b0, 1'b0);
    chk("accept_timeout", 32'(last_acc), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 6'd0, 7'd0, 1'b0, 1'b0);
  endtask

  initial begin
    npass = 0; ntotal = 0; nbeats_model = 0; nbeats_dut = 0;
    held_op = '0; held_idx = '0; last_acc = 1'b0;
    rst = 1'b1; instr_valid = 1'b0; instr_opcode = '0; instr_pchidx = '0;
    instr_pchnum = '0; pchwr_stall = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    idle(2);
    // Basic: idx 5,6,7
    issue(4'd3, 6'd5, 7'd3);
    idle(4);
    // Stall on the second beat for three cycles
    issue(4'd3, 6'd5, 7'd3);
    step(1'b0, 4'd0, 6'd0, 7'd0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 4'd0, 6'd0, 7'd0, 1'b1, 1'b0);
    idle(4);
    // Index wrap: 34,35,0,1
    issue(4'd5, 6'd34, 7'd4);
    idle(5);
    // RUN_ESM: single beat at idx 0
    issue(RUN_ESM, 6'd9, 7'd10);
    idle(3);
    // Back-to-back with no bubble
    issue(4'd3, 6'd10, 7'd2);
    issue(4'd2, 6'd0, 7'd1);
    idle(3);
    // Empty instruction consumed silently
    issue(4'd7, 6'd3, 7'd0);
    idle(2);
    // Stall with topsu_valid low has no effect
    step(1'b0, 4'd0, 6'd0, 7'd0, 1'b1, 1'b0);
    // Full ring of patches
    issue(4'd6, 6'd20, 7'd36);
    idle(40);
    // Reset after the second beat of a five-beat instruction
    issue(4'd4, 6'd2, 7'd5);
    idle(2);
    step(1'b0, 4'd0, 6'd0, 7'd0, 1'b0, 1'b1);
    idle(6);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 6'($urandom_range(0, 35)),
           7'($urandom_range(0, 36)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));
    idle(45);

    chk("beat_count", 32'(nbeats_dut), 32'(nbeats_model));
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
